// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MAX_REQ = 8;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wr_data;
  logic [N_REQ-1:0]       grant;
  logic [ID_W-1:0]        owner_id;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic                   wr_strobe;

  modport master (
    output req, lock, wr_data,
    input  grant, owner_id, busy, q, wr_strobe
  );

  modport slave (
    input  req, lock, wr_data,
    output grant, owner_id, busy, q, wr_strobe
  );

endinterface

// File: rtl/shared_reg_arbiter_picker.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping.
module rr_priority_picker
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             found,
  output logic [ID_W-1:0]  winner
);

  logic [2*N_REQ-1:0] rotated;
  int                 w;

  // Doubling the vector turns the circular scan into a plain shift.
  assign rotated = {req, req} >> start;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    w      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        w     = int'(start) + i;
        if (w >= N_REQ) w = w - N_REQ;
        winner = ID_W'(w);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic                 clk,
  input logic                 reset,
  shared_reg_arbiter_if.slave bus
);

  localparam int ID_W = id_w(N_REQ);
  localparam int HC_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);

  state_t             state;
  logic [N_REQ-1:0]   grant_r;
  logic [ID_W-1:0]    owner_r;
  logic [ID_W-1:0]    ptr;
  logic [HC_W-1:0]    hold_cnt;
  logic               busy_r;
  logic               wr_strobe_r;
  logic [WIDTH-1:0]   q_r;

  logic [ID_W-1:0]    o;
  logic [ID_W-1:0]    nxt_ptr;
  logic [ID_W-1:0]    pick_start;
  logic               found;
  logic [ID_W-1:0]    winner;
  logic               owner_req;
  logic               owner_lock;
  logic               release_now;
  logic               wr_en;
  logic [WIDTH-1:0]   owner_data;

  assign o          = ID_W'(onehot_to_idx(MAX_REQ'(grant_r)));
  assign nxt_ptr    = (o == ID_W'(N_REQ - 1)) ? '0 : o + ID_W'(1);
  // Release-time arbitration starts just past the owner, giving it lowest priority.
  assign pick_start = (state == IDLE) ? ptr : nxt_ptr;

  assign owner_req   = bus.req[o];
  assign owner_lock  = bus.lock[o];
  assign release_now = !owner_req || !owner_lock || (hold_cnt == HC_W'(MAX_HOLD - 1));
  assign wr_en       = (state == BUSY) && owner_req;
  assign owner_data  = bus.wr_data[int'(o)*WIDTH +: WIDTH];

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req    (bus.req),
    .start  (pick_start),
    .found  (found),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      grant_r     <= '0;
      owner_r     <= '0;
      busy_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr_strobe_r <= 1'b0;
          if (found) begin
            state    <= BUSY;
            grant_r  <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
            owner_r  <= winner;
            busy_r   <= 1'b1;
            hold_cnt <= '0;
          end
        end
        BUSY: begin
          wr_strobe_r <= owner_req;
          if (release_now) begin
            ptr <= nxt_ptr;
            if (found) begin
              grant_r  <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
              owner_r  <= winner;
              hold_cnt <= '0;
            end else begin
              state    <= IDLE;
              grant_r  <= '0;
              owner_r  <= '0;
              busy_r   <= 1'b0;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          grant_r <= '0;
          owner_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // The shared storage register; reset clears it, which also drops any in-flight write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r <= '0;
    end else if (wr_en) begin
      q_r <= owner_data;
    end
  end

  assign bus.grant     = grant_r;
  assign bus.owner_id  = owner_r;
  assign bus.busy      = busy_r;
  assign bus.q         = q_r;
  assign bus.wr_strobe = wr_strobe_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed plus randomized bench for shared_reg_arbiter against a behavioural model.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  shared_reg_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner -1 means idle.
  int         m_owner  = -1;
  int         m_ptr    = 0;
  int         m_hold   = 0;
  logic [W-1:0] m_q    = '0;
  logic       m_strobe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (start + i) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (!reset) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_q = '0; m_strobe = 1'b0;
    end else if (m_owner < 0) begin
      m_strobe = 1'b0;
      w = pick(bus.req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 0;
      end
    end else begin
      if (bus.req[m_owner]) begin
        m_q      = bus.wr_data[m_owner*W +: W];
        m_strobe = 1'b1;
      end else begin
        m_strobe = 1'b0;
      end
      if (!bus.req[m_owner] || !bus.lock[m_owner] || m_hold == MH - 1) begin
        m_ptr = (m_owner + 1) % N;
        w = pick(bus.req, m_ptr);
        m_owner = w;
        m_hold  = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    chk("m_grant",  bus.grant,     eg);
    chk("m_owner",  bus.owner_id,  (m_owner < 0) ? 0 : m_owner);
    chk("m_busy",   bus.busy,      m_owner >= 0);
    chk("m_q",      bus.q,         m_q);
    chk("m_strobe", bus.wr_strobe, m_strobe);
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N*W-1:0] d);
    reset       = rst;
    bus.req     = r;
    bus.lock    = l;
    bus.wr_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] exp_g;
    int           exp_i;
    int           nwr;

    // Reset held with every request asserted
    drive(1'b0, 4'b1111, 4'b0000, '0);
    step(); step();
    chk("rst_grant", bus.grant, 0);
    chk("rst_q",     bus.q,     0);
    chk("rst_busy",  bus.busy,  0);

    // Single-shot access and its latency
    drive(1'b1, 4'b0001, 4'b0000, 32'h0000_00A5);
    step();
    chk("first_grant",   bus.grant, 4'b0001);
    chk("first_q_early", bus.q,     0);
    step();
    chk("first_q",      bus.q,         8'hA5);
    chk("first_strobe", bus.wr_strobe, 1);
    drive(1'b1, 4'b0000, 4'b0000, 32'h0000_00A5);
    step();
    chk("strobe_once", bus.wr_strobe, 0);
    chk("idle_after",  bus.grant,     0);

    // Full rotation; ptr sits at 1 after owner 0 released
    drive(1'b1, 4'b1111, 4'b0000, 32'h1312_1110);
    step();
    exp_g = 4'b0010;
    chk("rot_start", bus.grant, exp_g);
    for (int k = 0; k < 5; k++) begin
      exp_i = 0;
      for (int b = 0; b < N; b++) if (exp_g[b]) exp_i = b;
      exp_g = {exp_g[N-2:0], exp_g[N-1]};
      step();
      chk("rot_grant", bus.grant, exp_g);
      chk("rot_q",     bus.q,     8'h10 + exp_i);
      chk("rot_busy",  bus.busy,  1);
    end
    drive(1'b1, 4'b0000, 4'b0000, '0);
    step();

    // Burst cap with lock[0] held
    drive(1'b0, 4'b0000, 4'b0000, '0);
    step();
    drive(1'b1, 4'b0011, 4'b0001, 32'h0000_2244);
    step();
    chk("burst_grant0", bus.grant, 4'b0001);
    nwr = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      nwr += int'(bus.wr_strobe);
      if (k < 3) chk("burst_hold", bus.grant, 4'b0001);
    end
    chk("burst_cap_move", bus.grant, 4'b0010);
    chk("burst_writes",   nwr,       4);
    chk("burst_q",        bus.q,     8'h44);
    drive(1'b1, 4'b0000, 4'b0000, '0);
    step(); step();

    // Early drop of req by the burst owner
    drive(1'b0, 4'b0000, 4'b0000, '0);
    step();
    drive(1'b1, 4'b0011, 4'b0011, 32'h0000_0055);
    step();
    chk("drop_grant0", bus.grant, 4'b0001);
    step();
    chk("drop_q1",      bus.q,         8'h55);
    chk("drop_strobe1", bus.wr_strobe, 1);
    drive(1'b1, 4'b0010, 4'b0011, 32'h0000_0066);
    step();
    chk("drop_grant",  bus.grant,     4'b0010);
    chk("drop_q_kept", bus.q,         8'h55);
    chk("drop_strobe", bus.wr_strobe, 0);
    drive(1'b1, 4'b0000, 4'b0000, '0);
    step();

    // Wrap-around and fairness
    drive(1'b0, 4'b0000, 4'b0000, '0);
    step();
    drive(1'b1, 4'b1000, 4'b0000, '0);
    step();
    chk("wrap_own3", bus.grant, 4'b1000);
    drive(1'b1, 4'b1001, 4'b0000, '0);
    step();
    chk("wrap_to0",   bus.grant,    4'b0001);
    chk("wrap_owner", bus.owner_id, 0);
    step();
    chk("fair_to3",   bus.grant,    4'b1000);
    chk("fair_owner", bus.owner_id, 3);
    drive(1'b1, 4'b0000, 4'b0000, '0);
    step();

    // Reset in the middle of owner 2's burst
    drive(1'b0, 4'b0000, 4'b0000, '0);
    step();
    drive(1'b1, 4'b0100, 4'b0100, 32'h0077_0000);
    step();
    chk("mid_grant2", bus.grant, 4'b0100);
    step();
    chk("mid_q", bus.q, 8'h77);
    drive(1'b0, 4'b0100, 4'b0100, 32'h0088_0000);
    step();
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_q",     bus.q,     0);
    chk("mid_rst_busy",  bus.busy,  0);
    drive(1'b1, 4'b0100, 4'b0100, 32'h0088_0000);
    step();
    chk("mid_regrant", bus.grant, 4'b0100);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) != 0),
            N'($urandom),
            N'($urandom | $urandom),
            (N*W)'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register among N_REQ requesters. Each requester raises req and gets a registered one-hot grant. While it holds the grant, the owner's wr_data is clocked into the register. A lock input allows multi-cycle bursts, capped at MAX_HOLD cycles so no requester starves. It sits between the lab datapath masters and the shared register.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, register/data width in bits
MAX_HOLD, 4, maximum consecutive owned cycles per grant (>=1)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (reset==0 at posedge clears state)
req  input  N_REQ  per-requester access request
lock  input  N_REQ  per-requester burst request; meaningful only while owner
wr_data  input  N_REQ*WIDTH  packed data; requester i drives bits [i*WIDTH +: WIDTH]
grant  output  N_REQ  registered one-hot ownership (all-zero when idle)
owner_id  output  clog2(N_REQ)  index of current owner; 0 when idle
busy  output  1  high in BUSY state
q  output  WIDTH  shared register contents
wr_strobe  output  1  registered; high for one cycle after each register write

Behaviour:
- Reset (reset==0 at posedge) clears everything regardless of other inputs: state=IDLE, grant=0, owner_id=0, busy=0, q=0, wr_strobe=0, ptr=0, hold_cnt=0. Reset mid-burst aborts with no write.
- FSM states:
  - IDLE: if any req bit is set, pick the winner by round-robin from ptr. At the edge, grant<=onehot(winner), owner_id<=winner, hold_cnt<=0, and go to BUSY. If no req is set, stay in IDLE.
  - BUSY, with owner o:
    - Write: if req[o]=1 at the edge, q<=wr_data[o] and wr_strobe<=1; otherwise no write and wr_strobe<=0.
    - Release: the grant is released at this edge if any of req[o]=0, lock[o]=0, or hold_cnt==MAX_HOLD-1. If none hold, hold_cnt++ and stay.
    - On release: ptr<=(o+1) mod N_REQ. Re-arbitrate at the same edge over req with priority starting at o+1, so o has lowest priority. If a winner exists, the grant moves to it with no idle cycle and hold_cnt<=0. Otherwise go to IDLE and grant<=0.
- Latency: a request seen at edge t gives a grant visible in cycle t+1. The first write lands at edge t+1, and q is updated in cycle t+2.
- Single-shot grant (lock=0) gives exactly one write, then release.
- A locked burst gives at most MAX_HOLD writes.
- req[o] dropping releases the grant at that edge with no write.
- Round robin: priority order is ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ). Wrap-around from N_REQ-1 to 0 is required.
- lock and req of non-owners are ignored for data. Requesters are never granted without req.
- grant is always one-hot or zero; owner_id always matches grant.

Decomposition:
- Package shared_reg_arbiter_pkg holds:
  - state enum {IDLE, BUSY}
  - ID_W = clog2(N_REQ) helper
  - the onehot-to-index function
- Sub-module rr_priority_picker (combinational): inputs req and start index; outputs found flag and winner index. It is used for both IDLE and release-time arbitration.
- q is a plain WIDTH-bit flip-flop bank with write enable, inside the top level.

Test Plan:
- Reset with requests: reset=0 for 2 cycles with req=4'b1111 -> grant=0, q=0, busy=0. Then reset=1, req=4'b0001, lock=0, wr_data[0]=8'hA5 -> grant=4'b0001 next cycle, q=8'hA5 the cycle after, wr_strobe pulses once.
- Full rotation: req=4'b1111, lock=0, data i = 8'h10+i held steady -> grant sequence 0001,0010,0100,1000,0001 with no idle gaps; q sequence 10,11,12,13,10.
- Burst cap: MAX_HOLD=4, req=4'b0011, lock[0] held high -> grant=0001 for exactly 4 cycles with 4 writes, then 0010 although lock[0] is still high.
- Early drop: owner 0 in burst, req[0] falls in cycle 2 of the grant -> release at that edge, q keeps the cycle-1 value, wr_strobe=0, next owner per round robin.
- Wrap and fairness: last owner 3, req=4'b1001 -> next grant 0001, not 1000; last owner 0, req=4'b1001 -> grant 1000.
- Reset mid-burst: reset=0 during owner 2 burst -> next cycle grant=0, q=0, busy=0. After reset=1 with req=4'b0100 -> grant 0100, because ptr returned to 0 and only req[2] is set.
